// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO bit serializer: FSM state encoding,
// default word width and the outgoing-bit selector.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The word is zero-extended to 32 bits, so msb_idx names the word's real top bit.
  function automatic logic next_bit(input logic [31:0] shreg,
                                    input logic [4:0]  msb_idx,
                                    input logic        msb_first);
    return msb_first ? shreg[msb_idx] : shreg[0];
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit counter for the serializer: synchronous clear/enable, terminal-count flag
// at WIDTH-1, asynchronous active-high reset.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  assign tc = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out serializer feeding the serial sequence detector.
// Optional trailing even-parity bit is built when PISO_PARITY_EN is defined.
module piso_bit_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d,
  output logic             d_valid,
  output logic             busy
);

  localparam logic [4:0] MSB_IDX = 5'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_shift;
  logic [CW-1:0]    count;
  logic             tc;
  logic             last_cycle;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_en;
`ifdef PISO_PARITY_EN
  logic             parity;
`endif

`ifdef PISO_PARITY_EN
  assign last_cycle = (state == PARITY);
`else
  assign last_cycle = (state == SHIFT) && tc;
`endif

  assign load_ready = (state == IDLE) || last_cycle;
  assign accept     = load_valid && load_ready;
  assign busy       = (state != IDLE);
  assign sh_shift   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

  // Counter restarts on every accepted word and parks at zero once the data bits are out.
  assign cnt_clr = accept || tc;
  assign cnt_en  = (state == SHIFT) && !tc;

  piso_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      d       <= 1'b0;
      d_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (accept) begin
      state   <= SHIFT;
      shreg   <= load_data;
      d       <= next_bit(32'(load_data), MSB_IDX, MSB_FIRST);
      d_valid <= 1'b1;
`ifdef PISO_PARITY_EN
      parity  <= ^load_data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (!tc) begin
            shreg <= sh_shift;
            d     <= next_bit(32'(sh_shift), MSB_IDX, MSB_FIRST);
          end else begin
`ifdef PISO_PARITY_EN
            state <= PARITY;
            d     <= parity;
`else
            // d keeps the last bit so the detector sees no toggle while idle.
            state   <= IDLE;
            d_valid <= 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state   <= IDLE;
          d_valid <= 1'b0;
        end
`endif
        default: begin
          d_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
